// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - instruction memory fetch request/response bundle
interface pc_fetch_ctrl_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC register and single-outstanding instruction fetch sequencer
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             PCNext,
    input  logic                    InstrAck,
    output logic [31:0]             PC,
    output logic [31:0]             Instr,
    output logic                    InstrValid,
    output logic                    MisalignTrap,
    output logic [31:0]             RetireCount,
    pc_fetch_ctrl_if.master         imem
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_VALID = 2'd3;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_trap;
    logic [31:0] r_retire_count;

    logic        w_ack_accept;
    logic        w_misaligned;

    assign w_ack_accept = (r_state == ST_VALID) && InstrAck;
    assign w_misaligned = (PCNext[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_pc           <= RESET_VECTOR;
            r_instr        <= NOP;
            r_trap         <= 1'b0;
            r_retire_count <= 32'd0;
        end else begin
            r_trap <= 1'b0;
            case (r_state)
                ST_IDLE: r_state <= ST_REQ;
                ST_REQ: begin
                    if (imem.imem_req_ready) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        r_instr <= imem.imem_rsp_data;
                        r_state <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (w_ack_accept) begin
                        r_retire_count <= r_retire_count + 32'd1;
                        // Misaligned targets are redirected; the trap pulse lines up with PC showing the vector
                        if (w_misaligned) begin
                            r_pc   <= TRAP_VECTOR;
                            r_trap <= 1'b1;
                        end else begin
                            r_pc <= PCNext;
                        end
                        r_state <= ST_REQ;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign imem.imem_req_valid = (r_state == ST_REQ);
    assign imem.imem_req_addr  = r_pc;

    assign PC           = r_pc;
    assign Instr        = r_instr;
    assign InstrValid   = (r_state == ST_VALID);
    assign MisalignTrap = r_trap;
    assign RetireCount  = r_retire_count;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed scoreboard bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] TV  = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_t;

    logic        clk;
    logic        rst;
    logic [31:0] PCNext;
    logic        InstrAck;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        MisalignTrap;
    logic [31:0] RetireCount;

    pc_fetch_ctrl_if imem ();

    pc_fetch_ctrl #(
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .PCNext       (PCNext),
        .InstrAck     (InstrAck),
        .PC           (PC),
        .Instr        (Instr),
        .InstrValid   (InstrValid),
        .MisalignTrap (MisalignTrap),
        .RetireCount  (RetireCount),
        .imem         (imem.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    fetch_t      exp_q[$];
    fetch_t      sb;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_count;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered in a REQ cycle; leaves the DUT in VALID holding the scoreboarded word
    task automatic do_fetch(input logic [31:0] data, input int stall);
        for (int i = 0; i < stall; i++) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = 32'hDEAD_BEEF;
            check("stall_req_valid", {31'd0, imem.imem_req_valid}, 32'd1);
            check("stall_req_addr", imem.imem_req_addr, m_pc);
            check("stall_instr_valid", {31'd0, InstrValid}, 32'd0);
            tick;
            check("stall_instr_held", Instr, m_instr);
        end
        imem.imem_rsp_valid = 1'b0;
        check("req_valid", {31'd0, imem.imem_req_valid}, 32'd1);
        check("req_addr", imem.imem_req_addr, m_pc);
        imem.imem_req_ready = 1'b1;
        exp_q.push_back('{addr: m_pc, data: data});
        tick;
        imem.imem_req_ready = 1'b0;
        check("wait_req_valid", {31'd0, imem.imem_req_valid}, 32'd0);
        check("wait_trap_low", {31'd0, MisalignTrap}, 32'd0);
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = data;
        tick;
        imem.imem_rsp_valid = 1'b0;
        check("instr_valid", {31'd0, InstrValid}, 32'd1);
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            sb = exp_q.pop_front();
            check("sb_pc", PC, sb.addr);
            check("sb_instr", Instr, sb.data);
            m_instr = sb.data;
        end
    endtask

    initial begin
        rst                 = 1'b1;
        InstrAck            = 1'b0;
        PCNext              = 32'd0;
        imem.imem_req_ready = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'd0;
        m_pc                = RV;
        m_instr             = NOP;
        m_count             = 32'd0;
        tick;
        tick;
        check("rst_pc", PC, RV);
        check("rst_instr", Instr, NOP);
        check("rst_instr_valid", {31'd0, InstrValid}, 32'd0);
        check("rst_req_valid", {31'd0, imem.imem_req_valid}, 32'd0);
        check("rst_trap", {31'd0, MisalignTrap}, 32'd0);
        check("rst_count", RetireCount, 32'd0);

        rst = 1'b0;
        check("idle_req_valid", {31'd0, imem.imem_req_valid}, 32'd0);
        tick;
        do_fetch(32'h0050_0093, 0);

        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = 32'hBAD0_0BAD;
        tick;
        imem.imem_rsp_valid = 1'b0;
        check("spurious_valid_instr", Instr, m_instr);
        check("spurious_valid_pc", PC, m_pc);
        check("spurious_still_valid", {31'd0, InstrValid}, 32'd1);

        InstrAck = 1'b1;
        PCNext   = 32'h0000_0040;
        tick;
        m_pc    = 32'h0000_0040;
        m_count = m_count + 32'd1;
        PCNext  = 32'h0000_0080;
        check("ack_pc", PC, m_pc);
        check("ack_count", RetireCount, m_count);
        check("ack_trap", {31'd0, MisalignTrap}, 32'd0);
        do_fetch(32'h0010_0113, 3);
        InstrAck = 1'b0;
        check("held_ack_count", RetireCount, m_count);
        check("held_ack_pc", PC, m_pc);

        InstrAck = 1'b1;
        PCNext   = 32'h0000_0042;
        tick;
        InstrAck = 1'b0;
        m_pc     = TV;
        m_count  = m_count + 32'd1;
        check("mis_pc", PC, TV);
        check("mis_trap", {31'd0, MisalignTrap}, 32'd1);
        check("mis_count", RetireCount, m_count);
        do_fetch(32'h0020_0193, 0);

        InstrAck = 1'b1;
        PCNext   = 32'h0000_0200;
        tick;
        InstrAck = 1'b0;
        m_count  = m_count + 32'd1;
        check("pre_rst_pc", PC, 32'h0000_0200);
        imem.imem_req_ready = 1'b1;
        tick;
        imem.imem_req_ready = 1'b0;
        rst                 = 1'b1;
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = 32'h1234_5678;
        InstrAck            = 1'b1;
        tick;
        rst                 = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        InstrAck            = 1'b0;
        m_pc                = RV;
        m_instr             = NOP;
        m_count             = 32'd0;
        check("wait_rst_instr", Instr, NOP);
        check("wait_rst_instr_valid", {31'd0, InstrValid}, 32'd0);
        check("wait_rst_pc", PC, RV);
        check("wait_rst_count", RetireCount, 32'd0);
        check("wait_rst_idle", {31'd0, imem.imem_req_valid}, 32'd0);
        tick;
        do_fetch(32'h0030_0213, 1);

        force dut.r_retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_count;
        check("preload_count", RetireCount, 32'hFFFF_FFFF);
        InstrAck = 1'b1;
        PCNext   = 32'h0000_0004;
        tick;
        InstrAck = 1'b0;
        m_pc     = 32'h0000_0004;
        check("wrap_count", RetireCount, 32'd0);
        check("wrap_pc", PC, m_pc);
        do_fetch(32'h0040_0293, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
